pipe_control: RTL

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/pipe_control.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_control.sv
// pipe_control: single-issue decode stage with load-use and multiply stall control.
//
// Decodes one 32-bit instruction per accepted handshake into a registered
// control word. It stalls upstream for one cycle on a load-use hazard and for
// MUL_LAT-1 cycles after a multiply.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   in_valid          upstream has an instruction
//   instruction[31:0] encoded instruction
//   in_ready          combinational; instruction consumed when in_valid && in_ready
//   out_valid         registered decoded word valid (0 = bubble)
//   reg_write, mem_read, mem_write, alu_src_imm   registered control strobes
//   alu_op[1:0]       00 add, 01 sub, 10 mul, 11 pass
//   src_a, src_b, dst_reg [REG_AW-1:0]            registered register addresses
//   imm[15:0]         registered instruction[15:0]
//   illegal           registered; unsupported encoding
//   mul_done          one-cycle pulse as multiply occupancy ends
//   stall_count[15:0] saturating count of stall cycles
module pipe_control #(
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned MUL_LAT   = 3,
    parameter int unsigned HAZARD_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       instruction,
    output logic              in_ready,
    output logic              out_valid,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              alu_src_imm,
    output logic [1:0]        alu_op,
    output logic [REG_AW-1:0] src_a,
    output logic [REG_AW-1:0] src_b,
    output logic [REG_AW-1:0] dst_reg,
    output logic [15:0]       imm,
    output logic              illegal,
    output logic              mul_done,
    output logic [15:0]       stall_count
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned STALL_W  = 16;

    localparam logic [5:0] OP_RGRP   = 6'b000100;
    localparam logic [5:0] OP_LW     = 6'b000101;
    localparam logic [5:0] OP_SW     = 6'b000110;
    localparam logic [5:0] FN_NOP    = 6'b000000;
    localparam logic [5:0] FN_ADD    = 6'b100000;
    localparam logic [5:0] FN_SUB    = 6'b100010;
    localparam logic [5:0] FN_MUL    = 6'b110010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_MUL   = 2'b10;

    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    // Decoded control word as it appears on the outputs.
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src_imm;
        logic [1:0]        alu_op;
        logic [REG_AW-1:0] src_a;
        logic [REG_AW-1:0] src_b;
        logic [REG_AW-1:0] dst_reg;
        logic [15:0]       imm;
        logic              illegal;
    } word_t;

    state_t              state_q, state_d;
    word_t               word_q, word_d;
    logic [CNT_W-1:0]    mul_cnt_q, mul_cnt_d;
    logic [REG_AW-1:0]   lw_dst_q, lw_dst_d;
    logic                mul_done_q, mul_done_d;
    logic [STALL_W-1:0]  stall_count_q, stall_count_d;

    logic [5:0]          f_op;
    logic [5:0]          f_funct;
    logic [REG_AW-1:0]   f_rt;
    logic [REG_AW-1:0]   f_rs;
    logic [REG_AW-1:0]   f_rd;

    word_t               dec;
    logic                dec_is_lw;
    logic                dec_is_mul;
    logic                hazard;
    logic                accept;
    logic                stall;

    // Field extraction at fixed positions, resized to the register-address width.
    assign f_op    = instruction[31:26];
    assign f_rt    = REG_AW'(instruction[25:21]);
    assign f_rs    = REG_AW'(instruction[20:16]);
    assign f_rd    = REG_AW'(instruction[15:11]);
    assign f_funct = instruction[5:0];

    // Instruction decode; NOP and illegal words leave every strobe and address at 0.
    always_comb begin
        dec        = '0;
        dec_is_lw  = 1'b0;
        dec_is_mul = 1'b0;
        dec.valid  = 1'b1;
        dec.imm    = instruction[15:0];
        case (f_op)
            OP_RGRP: begin
                case (f_funct)
                    FN_ADD, FN_SUB, FN_MUL: begin
                        dec.reg_write = 1'b1;
                        dec.src_a     = f_rt;
                        dec.src_b     = f_rs;
                        dec.dst_reg   = f_rd;
                        if (f_funct == FN_SUB) begin
                            dec.alu_op = ALU_SUB;
                        end else if (f_funct == FN_MUL) begin
                            dec.alu_op = ALU_MUL;
                            dec_is_mul = 1'b1;
                        end else begin
                            dec.alu_op = ALU_ADD;
                        end
                    end
                    FN_NOP: begin
                    end
                    default: begin
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                dec.mem_read    = 1'b1;
                dec.reg_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.alu_op      = ALU_ADD;
                dec.src_a       = f_rs;
                dec.dst_reg     = f_rt;
                dec_is_lw       = 1'b1;
            end
            OP_SW: begin
                dec.mem_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.alu_op      = ALU_ADD;
                dec.src_a       = f_rs;
                dec.src_b       = f_rt;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Load-use: the lw accepted last cycle targets a register this instruction reads.
    // Unused source fields decode to 0, and a load into register 0 is never recorded.
    assign hazard = (HAZARD_EN != 0) && in_valid && (lw_dst_q != '0) &&
                    ((dec.src_a == lw_dst_q) || (dec.src_b == lw_dst_q));

    assign in_ready = (state_q == RUN) && !hazard;
    assign accept   = in_valid && in_ready;

    // Next-state, next-output word and stall bookkeeping.
    always_comb begin
        state_d    = state_q;
        mul_cnt_d  = mul_cnt_q;
        word_d     = '0;
        lw_dst_d   = '0;
        mul_done_d = 1'b0;
        stall      = 1'b0;
        case (state_q)
            RUN: begin
                if (accept) begin
                    word_d = dec;
                    if (dec_is_lw) begin
                        lw_dst_d = dec.dst_reg;
                    end
                    if (dec_is_mul) begin
                        // Pulse lands with the output word (MUL_LAT=1) or in the
                        // single busy cycle (MUL_LAT=2); longer ops pulse from MUL_BUSY.
                        mul_done_d = (MUL_LAT <= 2);
                        if (MUL_LAT > 1) begin
                            state_d   = MUL_BUSY;
                            mul_cnt_d = CNT_W'(MUL_LAT - 1);
                        end
                    end
                end else if (hazard) begin
                    stall = 1'b1;
                end
            end
            MUL_BUSY: begin
                stall     = 1'b1;
                mul_cnt_d = mul_cnt_q - CNT_W'(1);
                // Registered pulse must be visible during the last busy cycle.
                mul_done_d = (mul_cnt_q == CNT_W'(2));
                if (mul_cnt_q <= CNT_W'(1)) begin
                    state_d   = RUN;
                    mul_cnt_d = '0;
                end
            end
            default: begin
                state_d   = RUN;
                mul_cnt_d = '0;
            end
        endcase

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != STALL_MAX)) begin
            stall_count_d = stall_count_q + STALL_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            word_q        <= '0;
            mul_cnt_q     <= '0;
            lw_dst_q      <= '0;
            mul_done_q    <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            mul_cnt_q     <= mul_cnt_d;
            lw_dst_q      <= lw_dst_d;
            mul_done_q    <= mul_done_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign out_valid   = word_q.valid;
    assign reg_write   = word_q.reg_write;
    assign mem_read    = word_q.mem_read;
    assign mem_write   = word_q.mem_write;
    assign alu_src_imm = word_q.alu_src_imm;
    assign alu_op      = word_q.alu_op;
    assign src_a       = word_q.src_a;
    assign src_b       = word_q.src_b;
    assign dst_reg     = word_q.dst_reg;
    assign imm         = word_q.imm;
    assign illegal     = word_q.illegal;
    assign mul_done    = mul_done_q;
    assign stall_count = stall_count_q;

endmodule
